tube_scanner: RTL

Time-multiplexed scan driver for the four-digit seven-segment display. It consumes the 32-bit parallel segment word produced by the 4-digit decoder (four 8-bit active-low patterns, DP in bit 7) and drives one shared 8-bit segment bus plus four active-low digit selects. It double-buffers the pattern to prevent tearing, inserts ghosting guard time, and applies 8-level brightness by duty.

---
 rtl/tube_pkg.sv | 13 +
 rtl/tube_slot_timer.sv | 62 ++++++
 rtl/tube_scanner.sv | 85 ++++++++
 3 files changed

// File: rtl/tube_pkg.sv
// rtl/tube_pkg.sv - shared constants and slot phase type for the tube scan driver
package tube_pkg;
    localparam int         NUM_DIGITS    = 4;
    localparam logic [7:0] SEG_BLANK     = 8'hFF;
    localparam logic [3:0] AN_OFF        = 4'hF;
    localparam int         BRIGHT_LEVELS = 8;

    typedef enum logic [1:0] {
        PH_GUARD,
        PH_ON,
        PH_OFF
    } slot_phase_t;
endpackage

// File: rtl/tube_slot_timer.sv
// rtl/tube_slot_timer.sv - per-digit slot counter, brightness latch and guard/on/off phase decode
module tube_slot_timer
    import tube_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] bright,
    output logic [1:0] phase,
    output logic [1:0] dig,
    output logic       slot_start,
    output logic       frame_end
);
    localparam int CW  = $clog2(SCAN_DIV);
    localparam int SUB = (SCAN_DIV - GUARD) / BRIGHT_LEVELS;
    localparam logic [CW:0] GUARD_W = (CW+1)'(GUARD);
    localparam logic [CW:0] SUB_W   = (CW+1)'(SUB);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [2:0]    bri_q;
    logic [CW:0]   on_end;
    logic          last_cycle;
    slot_phase_t   phase_d;

    assign last_cycle = (cnt_q == CW'(SCAN_DIV - 1));
    assign slot_start = (cnt_q == '0);
    assign frame_end  = last_cycle && (dig_q == 2'(NUM_DIGITS - 1));
    assign dig        = dig_q;
    assign phase      = phase_d;

    assign cnt_d = last_cycle ? '0 : cnt_q + CW'(1);
    assign dig_d = last_cycle ? dig_q + 2'd1 : dig_q;

    // One extra bit so GUARD + 8*SUB cannot wrap when SCAN_DIV is a power of two
    assign on_end = GUARD_W + ((CW+1)'(bri_q) + (CW+1)'(1)) * SUB_W;

    always_comb begin
        phase_d = PH_OFF;
        if ({1'b0, cnt_q} < GUARD_W) begin
            phase_d = PH_GUARD;
        end else if ({1'b0, cnt_q} < on_end) begin
            phase_d = PH_ON;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            dig_q <= '0;
            bri_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            dig_q <= dig_d;
            if (slot_start) begin
                bri_q <= bright;
            end
        end
    end
endmodule

// File: rtl/tube_scanner.sv
// rtl/tube_scanner.sv - four-digit seven-segment scan driver with double buffering and duty dimming
module tube_scanner
    import tube_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bit16drive,
    input  logic        load,
    input  logic [3:0]  digit_en,
    input  logic [2:0]  bright,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);
    logic [1:0]  phase;
    logic [1:0]  dig;
    logic        slot_start;
    logic        frame_end;

    logic [31:0] pend_q;
    logic        pend_valid_q;
    logic [31:0] active_q;
    logic [7:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        frame_done_q;

    tube_slot_timer #(
        .SCAN_DIV (SCAN_DIV),
        .GUARD    (GUARD)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .bright     (bright),
        .phase      (phase),
        .dig        (dig),
        .slot_start (slot_start),
        .frame_end  (frame_end)
    );

    // Slot cycle 0 stays dark: brightness for the slot is only latched on that cycle
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = AN_OFF;
        if (phase == PH_ON && digit_en[dig] && !slot_start) begin
            an_d  = ~(4'b0001 << dig);
            seg_d = active_q[8*dig +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= '1;
            pend_valid_q <= 1'b0;
            active_q     <= '1;
            seg_q        <= SEG_BLANK;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            if (load) begin
                pend_q       <= bit16drive;
                pend_valid_q <= 1'b1;
            end
            // Displayed word only swaps on the frame boundary so a frame never tears
            if (frame_end) begin
                if (load) begin
                    active_q     <= bit16drive;
                    pend_valid_q <= 1'b0;
                end else if (pend_valid_q) begin
                    active_q     <= pend_q;
                    pend_valid_q <= 1'b0;
                end
            end
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_end;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
endmodule
